// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM arbiter: owner-state encoding and the
// default SRAM word-address width.
package sram_arb_pkg;

  localparam int ADDR_W_DEF = 19;

  // Which access the SRAM bus is carrying in the current cycle.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VID_RD = 2'd1,
    CPU_RD = 2'd2,
    CPU_WR = 2'd3
  } owner_e;

endpackage

// File: rtl/sram_arbiter.sv
// Single-port SRAM arbiter between video scanout (read-only) and a CPU.
// One request is accepted per cycle, the SRAM access runs in the following
// cycle from registered pins, and read data returns one cycle after that.
// Video has priority, except that a CPU denied STARVE_MAX cycles in a row
// is given the next slot.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk_core,
  input  logic              reset,
  // video scanout port
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic              vid_rvalid,
  output logic [15:0]       vid_rdata,
  // CPU port
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [15:0]       cpu_wdata,
  input  logic [1:0]        cpu_be,
  output logic              cpu_ack,
  output logic              cpu_rvalid,
  output logic [15:0]       cpu_rdata,
  // SRAM pins
  output logic [ADDR_W-1:0] sram_a,
  output logic              sram_wr,
  output logic [1:0]        sram_be_n,
  output logic [15:0]       host_to_sram,
  input  logic [15:0]       sram_to_host
);

  localparam int                CNT_W      = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0]  STARVE_LIM = CNT_W'(STARVE_MAX);

  owner_e            state, state_nxt;
  logic [CNT_W-1:0]  starve_cnt;
  logic              cpu_wins;

  logic [ADDR_W-1:0] a_nxt;
  logic              wr_nxt;
  logic [1:0]        be_n_nxt;
  logic [15:0]       wdata_nxt;

  logic              vid_rvalid_q, cpu_rvalid_q;
  logic [15:0]       vid_rdata_q, cpu_rdata_q;

  // Arbitration: video wins a tie unless the CPU has been starved to the limit.
  always_comb begin
    cpu_wins = cpu_req && (!vid_req || (starve_cnt == STARVE_LIM));
    cpu_ack  = !reset && cpu_wins;
    vid_ack  = !reset && vid_req && !cpu_wins;
  end

  // Next owner and SRAM pin values for the access cycle after an accept.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_nxt = IDLE;
    a_nxt     = sram_a;          // address holds while idle
    wr_nxt    = 1'b0;
    be_n_nxt  = 2'b11;           // no lanes driven while idle
    wdata_nxt = host_to_sram;
    if (vid_ack) begin
      state_nxt = VID_RD;
      a_nxt     = vid_addr;
      be_n_nxt  = 2'b00;
    end else if (cpu_ack) begin
      a_nxt = cpu_addr;
      if (cpu_we) begin
        state_nxt = CPU_WR;
        wr_nxt    = 1'b1;
        be_n_nxt  = ~cpu_be;     // be=00 still runs a cycle, just with no lanes
        wdata_nxt = cpu_wdata;
      end else begin
        state_nxt = CPU_RD;
        be_n_nxt  = 2'b00;
      end
    end
  end

  // Owner state and registered SRAM pins, valid for exactly the access cycle.
  always_ff @(posedge clk_core) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (reset) begin
      state        <= IDLE;
      sram_a       <= '0;
      sram_wr      <= 1'b0;
      sram_be_n    <= 2'b11;
      host_to_sram <= '0;
    end else begin
      state        <= state_nxt;
      sram_a       <= a_nxt;
      sram_wr      <= wr_nxt;
      sram_be_n    <= be_n_nxt;
      host_to_sram <= wdata_nxt;
    end
  end

  // Starvation counter: counts consecutive CPU denials, saturating at the limit.
  always_ff @(posedge clk_core) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (cpu_req && !cpu_ack) begin
      if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 1'b1;
    end else begin
      starve_cnt <= '0;
    end
  end

  // Read return stage: capture SRAM data at the end of the access cycle.
  always_ff @(posedge clk_core) begin
    if (reset) begin
      vid_rvalid_q <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      vid_rdata_q  <= '0;
      cpu_rdata_q  <= '0;
    end else begin
      vid_rvalid_q <= (state == VID_RD);
      cpu_rvalid_q <= (state == CPU_RD);
      if (state == VID_RD) vid_rdata_q <= sram_to_host;
      if (state == CPU_RD) cpu_rdata_q <= sram_to_host;
    end
  end

  // Return outputs are blanked while reset is high so a read in flight when
  // reset arrives can never present valid data, even in the reset cycle itself.
  always_comb begin
    vid_rvalid = vid_rvalid_q && !reset;
    cpu_rvalid = cpu_rvalid_q && !reset;
    vid_rdata  = reset ? 16'h0000 : vid_rdata_q;
    cpu_rdata  = reset ? 16'h0000 : cpu_rdata_q;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ADDR_W, 19, SRAM word-address width.
REQ-002 Parameter STARVE_MAX, 8, consecutive CPU denials before CPU is forced a slot.
REQ-003 clk_core  in  1  core clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 vid_req  in  1  video scanout requests a read this cycle.
REQ-006 vid_addr  in  ADDR_W  video read address.
REQ-007 vid_ack  out  1  combinational; video request accepted this cycle.
REQ-008 vid_rvalid  out  1  vid_rdata valid this cycle.
REQ-009 vid_rdata  out  16  video read data.
REQ-010 cpu_req  in  1  CPU requests an access this cycle.
REQ-011 cpu_we  in  1  1 = write, 0 = read.
REQ-012 cpu_addr  in  ADDR_W  CPU address.
REQ-013 cpu_wdata  in  16  CPU write data.
REQ-014 cpu_be  in  2  byte enables, bit1 = upper byte.
REQ-015 cpu_ack  out  1  combinational; CPU request accepted this cycle.
REQ-016 cpu_rvalid  out  1  cpu_rdata valid this cycle.
REQ-017 cpu_rdata  out  16  CPU read data.
REQ-018 sram_a  out  ADDR_W  registered SRAM address.
REQ-019 sram_wr  out  1  registered; write strobe source, high for the whole access cycle.
REQ-020 sram_be_n  out  2  registered active-low byte lanes; 2'b00 on reads.
REQ-021 host_to_sram  out  16  registered write data.
REQ-022 sram_to_host  in  16  SRAM read data, sampled at the end of the access cycle.

Function
REQ-023 The block SHALL accept at most one request per cycle (acceptance cycle N), drive the access in cycle N+1, and hold sram_a/sram_wr/sram_be_n/host_to_sram for exactly that cycle.
REQ-024 Registered owner state SHALL be one of IDLE, VID_RD, CPU_RD, CPU_WR, naming the access in progress; with no request accepted in cycle N, state in N+1 is IDLE with sram_wr=0 and sram_a unchanged.
REQ-025 Priority: video wins when both request, unless starve_cnt == STARVE_MAX, in which case CPU wins.
REQ-026 starve_cnt SHALL increment (saturating at STARVE_MAX) each cycle cpu_req=1 and cpu_ack=0, and clear to 0 on any cycle cpu_ack=1 or cpu_req=0.
REQ-027 On a read, sram_to_host SHALL be captured at the end of cycle N+1 and presented with the owner's rvalid high for exactly cycle N+2; the other rvalid stays 0.
REQ-028 Back-to-back accepts SHALL sustain one access per cycle, including any mix of reads and writes, with no idle slot inserted.
REQ-029 CPU writes SHALL produce no rvalid; sram_be_n = ~cpu_be; cpu_be = 2'b00 is accepted and performs an access with no lanes enabled.
REQ-030 A requester SHALL hold req/addr/data stable until ack; deasserting req before ack is legal and cancels the request.

Reset
REQ-031 While reset=1: state=IDLE, sram_wr=0, sram_be_n=2'b11, sram_a=0, host_to_sram=0, starve_cnt=0, both rvalid=0, both rdata=0, both acks=0.
REQ-032 A read accepted before reset SHALL never produce rvalid, even if reset is asserted for a single cycle during N+1 or N+2.
REQ-033 The first accept is possible in the first cycle with reset=0.

Structure
REQ-034 Shared package sram_arb_pkg SHALL hold the owner-state encoding and the ADDR_W default; no other typedefs.
REQ-035 Implementation SHALL be a single module with no sub-module; the read-return pipeline is one registered stage.

Verification
REQ-036 Video-only read vid_addr=0x00010, SRAM model returns 0xBEEF -> vid_ack in N, sram_a=0x00010 in N+1, vid_rvalid=1 with vid_rdata=0xBEEF in N+2.
REQ-037 CPU write addr=0x7FFFF, wdata=0x1234, be=2'b01 -> cpu_ack in N, sram_wr=1, sram_be_n=2'b10, host_to_sram=0x1234 in N+1, no rvalid.
REQ-038 vid_req and cpu_req held high continuously -> cpu_ack=0 for 8 consecutive cycles, then cpu_ack=1 on the 9th cycle, then video resumes.
REQ-039 Alternating CPU write/read to the same address on consecutive cycles -> one access per cycle, and the read returns the written value 2 cycles after its acceptance.
REQ-040 Reset pulsed in the cycle after a CPU read accept -> cpu_rvalid stays 0, and all outputs match REQ-031 values.
